// File: rtl/seg7_pkg.sv
// Shared character codes, message IDs and glyph patterns for the
// multiplexed 7-segment message scanner.
package seg7_pkg;

    // 5-bit character codes
    localparam logic [4:0] CH_0     = 5'd0;
    localparam logic [4:0] CH_1     = 5'd1;
    localparam logic [4:0] CH_2     = 5'd2;
    localparam logic [4:0] CH_5     = 5'd5;
    localparam logic [4:0] CH_C     = 5'd12;
    localparam logic [4:0] CH_E     = 5'd14;
    localparam logic [4:0] CH_L     = 5'd16;
    localparam logic [4:0] CH_P     = 5'd17;
    localparam logic [4:0] CH_R     = 5'd18;
    localparam logic [4:0] CH_S     = 5'd19;
    localparam logic [4:0] CH_N     = 5'd20;
    localparam logic [4:0] CH_D     = 5'd21;
    localparam logic [4:0] CH_I     = 5'd22;
    localparam logic [4:0] CH_DASH  = 5'd23;
    localparam logic [4:0] CH_BLANK = 5'd31;

    // 4-bit message IDs; error messages occupy a contiguous range
    localparam logic [3:0] MSG_BLANK = 4'd0;
    localparam logic [3:0] MSG_WAIT  = 4'd1;
    localparam logic [3:0] MSG_CE01  = 4'd2;
    localparam logic [3:0] MSG_CL02  = 4'd3;
    localparam logic [3:0] MSG_CC05  = 4'd4;
    localparam logic [3:0] MSG_CP10  = 4'd5;
    localparam logic [3:0] MSG_ERSR  = 4'd6;
    localparam logic [3:0] MSG_ERSP  = 4'd7;
    localparam logic [3:0] MSG_ERSN  = 4'd8;
    localparam logic [3:0] MSG_ERDI  = 4'd9;

    // Active-high glyphs, bit 6 = a ... bit 0 = g
    localparam logic [6:0] GLY_0     = 7'h7E;
    localparam logic [6:0] GLY_1     = 7'h30;
    localparam logic [6:0] GLY_2     = 7'h6D;
    localparam logic [6:0] GLY_5     = 7'h5B;
    localparam logic [6:0] GLY_C     = 7'h4E;
    localparam logic [6:0] GLY_E     = 7'h4F;
    localparam logic [6:0] GLY_L     = 7'h0E;
    localparam logic [6:0] GLY_P     = 7'h67;
    localparam logic [6:0] GLY_R     = 7'h05;
    localparam logic [6:0] GLY_S     = 7'h5B;
    localparam logic [6:0] GLY_N     = 7'h15;
    localparam logic [6:0] GLY_D     = 7'h3D;
    localparam logic [6:0] GLY_I     = 7'h30;
    localparam logic [6:0] GLY_DASH  = 7'h01;
    localparam logic [6:0] GLY_BLANK = 7'h00;

    // Character at position 0..3 (0 = leftmost) of a text message
    function automatic logic [4:0] msg_char(input logic [3:0] msg_id, input logic [1:0] pos);
        logic [19:0] chars;
        case (msg_id)
            MSG_CE01: chars = {CH_C, CH_E, CH_0, CH_1};
            MSG_CL02: chars = {CH_C, CH_L, CH_0, CH_2};
            MSG_CC05: chars = {CH_C, CH_C, CH_0, CH_5};
            MSG_CP10: chars = {CH_C, CH_P, CH_1, CH_0};
            MSG_ERSR: chars = {CH_E, CH_R, CH_S, CH_R};
            MSG_ERSP: chars = {CH_E, CH_R, CH_S, CH_P};
            MSG_ERSN: chars = {CH_E, CH_R, CH_S, CH_N};
            MSG_ERDI: chars = {CH_E, CH_R, CH_D, CH_I};
            default:  chars = {4{CH_BLANK}};
        endcase
        case (pos)
            2'd0:    return chars[19:15];
            2'd1:    return chars[14:10];
            2'd2:    return chars[9:5];
            default: return chars[4:0];
        endcase
    endfunction

    function automatic logic is_error(input logic [3:0] msg_id);
        return (msg_id >= MSG_ERSR) && (msg_id <= MSG_ERDI);
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Character code to active-high 7-segment pattern; unknown codes are blank.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [4:0] i_char,
    output logic [6:0] o_seg_hi
);

    // Pure lookup, no state
    always_comb begin
        o_seg_hi = GLY_BLANK;
        case (i_char)
            CH_0:    o_seg_hi = GLY_0;
            CH_1:    o_seg_hi = GLY_1;
            CH_2:    o_seg_hi = GLY_2;
            CH_5:    o_seg_hi = GLY_5;
            CH_C:    o_seg_hi = GLY_C;
            CH_E:    o_seg_hi = GLY_E;
            CH_L:    o_seg_hi = GLY_L;
            CH_P:    o_seg_hi = GLY_P;
            CH_R:    o_seg_hi = GLY_R;
            CH_S:    o_seg_hi = GLY_S;
            CH_N:    o_seg_hi = GLY_N;
            CH_D:    o_seg_hi = GLY_D;
            CH_I:    o_seg_hi = GLY_I;
            CH_DASH: o_seg_hi = GLY_DASH;
            default: o_seg_hi = GLY_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_msg_scanner.sv
// Time-multiplexed common-anode 7-segment driver showing one prioritised
// status message, latched per scan frame, with error blinking and a
// wait-mode dash chase.
module seg7_msg_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned BLINK_DIV  = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            S,
    input  logic [3:0]            ERR,
    input  logic                  M,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] DIG
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_DIV - 1);

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [FW-1:0]         r_frame;
    logic                  r_blink_on;
    logic [IW-1:0]         r_anim;
    logic [3:0]            r_msg;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_dig;

    logic                  w_slot_tick;
    logic                  w_frame_start;
    logic [3:0]            w_sel;
    logic                  w_in_pad;
    logic [1:0]            w_pos;
    logic [4:0]            w_char;
    logic [6:0]            w_seg_hi;
    logic [6:0]            w_seg_gated;
    logic [NUM_DIGITS-1:0] w_dig_n;

    assign w_slot_tick   = (r_presc == PRESC_MAX);
    assign w_frame_start = w_slot_tick && (r_idx == IDX_MAX);

    // Prescaler and digit index scan
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            if (w_slot_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Fixed-priority message select: lowest error bit, lowest selection bit, wait, blank
    always_comb begin
        if      (ERR[0]) w_sel = MSG_ERSR;
        else if (ERR[1]) w_sel = MSG_ERSP;
        else if (ERR[2]) w_sel = MSG_ERSN;
        else if (ERR[3]) w_sel = MSG_ERDI;
        else if (S[0])   w_sel = MSG_CE01;
        else if (S[1])   w_sel = MSG_CL02;
        else if (S[2])   w_sel = MSG_CC05;
        else if (S[3])   w_sel = MSG_CP10;
        else if (M)      w_sel = MSG_WAIT;
        else             w_sel = MSG_BLANK;
    end

    // Message is captured only at frame boundaries so a frame is never mixed
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_msg <= MSG_BLANK;
        end else if (w_frame_start) begin
            r_msg <= w_sel;
        end
    end

    // Frame counter drives blink phase and wait-animation position
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame    <= '0;
            r_blink_on <= 1'b1;
            r_anim     <= '0;
        end else if (w_frame_start) begin
            if (r_frame == FRAME_MAX) begin
                r_frame    <= '0;
                r_blink_on <= ~r_blink_on;
                r_anim     <= (r_anim == IDX_MAX) ? '0 : r_anim + IW'(1);
            end else begin
                r_frame <= r_frame + FW'(1);
            end
        end
    end

    // Digits left of the 4-character message window are padding
    assign w_in_pad = ({1'b0, r_idx} + (IW + 1)'(4)) < (IW + 1)'(NUM_DIGITS);
    assign w_pos    = r_idx[1:0] - 2'(NUM_DIGITS - 4);

    // Character for the currently scanned digit
    always_comb begin
        w_char = CH_BLANK;
        if (r_msg == MSG_WAIT) begin
            if (r_idx == r_anim) w_char = CH_DASH;
        end else if (!w_in_pad) begin
            w_char = msg_char(r_msg, w_pos);
        end
    end

    seg7_glyph u_glyph (
        .i_char   (w_char),
        .o_seg_hi (w_seg_hi)
    );

    assign w_seg_gated = (is_error(r_msg) && !r_blink_on) ? GLY_BLANK : w_seg_hi;

    // Index 0 is the leftmost digit, i.e. the MSB of DIG
    always_comb begin
        w_dig_n = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(NUM_DIGITS - 1 - i)) w_dig_n[i] = 1'b0;
        end
    end

    // Output register: SEG and DIG share one stage so they never disagree
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_seg <= 7'h7F;
            r_dig <= '1;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= ~w_seg_gated;
            r_dig <= w_dig_n;
            r_dp  <= 1'b1;
        end
    end

    assign SEG = r_seg;
    assign DIG = r_dig;
    assign DP  = r_dp;

endmodule

// File: tb/tb_seg7_msg_scanner.sv
// Randomised bench for seg7_msg_scanner against a cycle-arithmetic model.
module tb_seg7_msg_scanner;

    localparam int N     = 4;
    localparam int P     = 4;
    localparam int B     = 2;
    localparam int FRAME = N * P;
    localparam int M_BLANK = -1;
    localparam int M_WAIT  = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [3:0]   S   = 4'h0;
    logic [3:0]   ERR = 4'h0;
    logic         M   = 1'b0;
    logic [6:0]   SEG;
    logic         DP;
    logic [N-1:0] DIG;

    int n_total = 0;
    int n_bad   = 0;
    int k       = 0;
    int hold    = 0;
    int latch_q[$];
    string msgs[8] = '{"ERSR", "ERSP", "ERSN", "ERDI", "CE01", "CL02", "CC05", "CP10"};

    seg7_msg_scanner #(
        .NUM_DIGITS (N),
        .PRESCALE   (P),
        .BLINK_DIV  (B)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .S   (S),
        .ERR (ERR),
        .M   (M),
        .SEG (SEG),
        .DP  (DP),
        .DIG (DIG)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d after reset)", tag, got, exp, k);
        end
    endtask

    // Active-high segments (a..g) for each character appearing in messages
    function automatic logic [6:0] glyph(input byte c);
        case (c)
            "0":     return 7'h7E;
            "1":     return 7'h30;
            "2":     return 7'h6D;
            "5":     return 7'h5B;
            "C":     return 7'h4E;
            "E":     return 7'h4F;
            "L":     return 7'h0E;
            "P":     return 7'h67;
            "R":     return 7'h05;
            "S":     return 7'h5B;
            "N":     return 7'h15;
            "D":     return 7'h3D;
            "I":     return 7'h30;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int pick(input logic [3:0] e, input logic [3:0] s, input logic m);
        for (int i = 0; i < 4; i++) if (e[i]) return i;
        for (int i = 0; i < 4; i++) if (s[i]) return 4 + i;
        return m ? M_WAIT : M_BLANK;
    endfunction

    // Expected SEG after the kk-th clock edge since reset release
    function automatic int exp_seg(input int kk);
        int fs = kk / FRAME;
        int idx = (kk / P) % N;
        int msg = latch_q[fs];
        bit on = ((fs / B) % 2) == 0;
        int anim = (fs / B) % N;
        logic [6:0] lo;
        if (msg == M_WAIT) return (idx == anim) ? 7'h7E : 7'h7F;
        if (msg == M_BLANK || idx < N - 4) return 7'h7F;
        if (msg < 4 && !on) return 7'h7F;
        lo = ~glyph(msgs[msg][idx - (N - 4)]);
        return int'(lo);
    endfunction

    function automatic int exp_dig(input int kk);
        int idx = (kk / P) % N;
        return ((1 << N) - 1) & ~(1 << (N - 1 - idx));
    endfunction

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            #1;
            check_eq("rst_seg", int'(SEG), 7'h7F);
            check_eq("rst_dig", int'(DIG), (1 << N) - 1);
            check_eq("rst_dp", int'(DP), 1);
            @(negedge CLK);
        end
        RST = 1'b0;
        k = 0;
        latch_q.delete();
        latch_q.push_back(M_BLANK);
    endtask

    task automatic new_inputs();
        case ($urandom_range(0, 3))
            0: begin
                ERR = 4'($urandom_range(1, 15));
                S   = 4'($urandom);
                M   = 1'($urandom);
            end
            1: begin
                ERR = 4'h0;
                S   = 4'($urandom_range(1, 15));
                M   = 1'($urandom);
            end
            2: begin
                ERR = 4'h0;
                S   = 4'h0;
                M   = 1'b1;
            end
            default: begin
                ERR = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                S   = 4'($urandom);
                M   = 1'($urandom);
            end
        endcase
    endtask

    // Called at a falling edge; inputs change only here, away from the active edge
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            if (hold == 0) begin
                new_inputs();
                hold = $urandom_range(1, 150);
            end
            hold--;
            if ((k + 1) % FRAME == 0) latch_q.push_back(pick(ERR, S, M));
            @(posedge CLK);
            #1;
            check_eq("seg", int'(SEG), exp_seg(k));
            check_eq("dig", int'(DIG), exp_dig(k));
            check_eq("dp", int'(DP), 1);
            k++;
            @(negedge CLK);
        end
    endtask

    initial begin
        @(negedge CLK);
        do_reset(3);
        run(600 + $urandom_range(0, 40));
        do_reset(1);
        run(500 + $urandom_range(0, 40));
        do_reset(2);
        run(400);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
